// File: rtl/multi_alarm_engine_pkg.sv
// Shared types and defaults for the multi-slot alarm engine.
// Slot FSM encoding, BCD time layout and the slot-index width helper.
package multi_alarm_engine_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t ms_hr;
        bcd_digit_t ls_hr;
        bcd_digit_t ms_min;
        bcd_digit_t ls_min;
    } bcd_time_t;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_RINGING = 2'd1,
        SLOT_SNOOZED = 2'd2
    } slot_state_e;

    localparam logic [1:0] ST_IDLE    = SLOT_IDLE;
    localparam logic [1:0] ST_RINGING = SLOT_RINGING;
    localparam logic [1:0] ST_SNOOZED = SLOT_SNOOZED;

    localparam int SNOOZE_MIN_DEFAULT       = 5;
    localparam int RING_TIMEOUT_MIN_DEFAULT = 10;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_alarm_engine_alarm_slot.sv
// One alarm slot: stored BCD time, enable bit, IDLE/RINGING/SNOOZED FSM
// with its ring-minute and snooze-countdown counters.
module alarm_slot
    import multi_alarm_engine_pkg::*;
#(
    parameter int SNOOZE_MIN       = SNOOZE_MIN_DEFAULT,
    parameter int RING_TIMEOUT_MIN = RING_TIMEOUT_MIN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       tick_d,
    input  bcd_time_t  current_time,
    input  logic       load,
    input  bcd_time_t  new_time,
    input  logic       enable_write,
    input  logic       enable_val,
    input  logic       snooze,
    input  logic       stop,
    output bcd_time_t  alarm_time,
    output logic [1:0] state_dbg
);

    localparam logic [3:0] SNOOZE_LOAD  = 4'(SNOOZE_MIN);
    localparam logic [3:0] TIMEOUT_LAST = 4'(RING_TIMEOUT_MIN - 1);

    logic [1:0] state;
    logic       enable;
    logic [3:0] ring_cnt;
    logic [3:0] snooze_cnt;
    logic       force_idle;
    logic       match;

    // Writes to this slot outrank every event, including stop/snooze/match.
    assign force_idle = load | (enable_write & ~enable_val);
    assign match      = tick_d & enable & (alarm_time == current_time);
    assign state_dbg  = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            alarm_time <= '0;
            enable     <= 1'b0;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
        end else begin
            if (load) begin
                alarm_time <= new_time;
            end
            if (enable_write) begin
                enable <= enable_val;
            end

            if (force_idle || stop) begin
                state      <= ST_IDLE;
                ring_cnt   <= '0;
                snooze_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (match) begin
                            state    <= ST_RINGING;
                            ring_cnt <= '0;
                        end
                    end
                    ST_RINGING: begin
                        if (snooze) begin
                            state      <= ST_SNOOZED;
                            snooze_cnt <= SNOOZE_LOAD;
                        end else if (one_minute) begin
                            if (ring_cnt == TIMEOUT_LAST) begin
                                state    <= ST_IDLE;
                                ring_cnt <= '0;
                            end else begin
                                ring_cnt <= ring_cnt + 4'd1;
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        // Countdown hitting zero re-arms the ring with a fresh timeout.
                        if (one_minute) begin
                            if (snooze_cnt == 4'd1) begin
                                state      <= ST_RINGING;
                                ring_cnt   <= '0;
                                snooze_cnt <= '0;
                            end else begin
                                snooze_cnt <= snooze_cnt - 4'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_alarm_engine.sv
// Multi-slot alarm engine: NUM_ALARMS independent alarm slots, fixed-priority
// selection of the ringing slot, and combinational readback of the selected slot.
module multi_alarm_engine
    import multi_alarm_engine_pkg::*;
#(
    parameter int  NUM_ALARMS       = 4,
    parameter int  SNOOZE_MIN       = SNOOZE_MIN_DEFAULT,
    parameter int  RING_TIMEOUT_MIN = RING_TIMEOUT_MIN_DEFAULT,
    localparam int IDX_W            = idx_width(NUM_ALARMS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  one_minute,
    input  logic [3:0]            current_time_ms_hr,
    input  logic [3:0]            current_time_ls_hr,
    input  logic [3:0]            current_time_ms_min,
    input  logic [3:0]            current_time_ls_min,
    input  logic                  load_new_alarm,
    input  logic [IDX_W-1:0]      alarm_sel,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
    input  logic                  set_enable,
    input  logic                  alarm_enable_val,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [3:0]            alarm_time_ms_hr,
    output logic [3:0]            alarm_time_ls_hr,
    output logic [3:0]            alarm_time_ms_min,
    output logic [3:0]            alarm_time_ls_min,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  alarm_sound,
    output logic [IDX_W-1:0]      active_alarm
);

    logic       tick_d;
    bcd_time_t  current_time;
    bcd_time_t  new_time;
    bcd_time_t  readback;
    bcd_time_t  slot_time  [NUM_ALARMS];
    logic [1:0] slot_state [NUM_ALARMS];

    assign current_time = {current_time_ms_hr, current_time_ls_hr,
                           current_time_ms_min, current_time_ls_min};
    assign new_time     = {new_alarm_ms_hr, new_alarm_ls_hr,
                           new_alarm_ms_min, new_alarm_ls_min};

    // The external time counter steps on the one_minute edge, so matching one
    // cycle later compares against the freshly incremented time.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= one_minute;
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
        logic sel_hit;
        assign sel_hit = (alarm_sel == IDX_W'(i));

        alarm_slot #(
            .SNOOZE_MIN       (SNOOZE_MIN),
            .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN)
        ) u_slot (
            .clock        (clock),
            .reset        (reset),
            .one_minute   (one_minute),
            .tick_d       (tick_d),
            .current_time (current_time),
            .load         (load_new_alarm & sel_hit),
            .new_time     (new_time),
            .enable_write (set_enable & sel_hit),
            .enable_val   (alarm_enable_val),
            .snooze       (snooze),
            .stop         (stop),
            .alarm_time   (slot_time[i]),
            .state_dbg    (slot_state[i])
        );

        assign ringing[i] = (slot_state[i] == ST_RINGING);
    end

    assign alarm_sound = |ringing;

    // Scan from the top down so the lowest ringing index wins.
    always_comb begin
        active_alarm = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) begin
                active_alarm = IDX_W'(i);
            end
        end
    end

    // Out-of-range selects match no slot and read back as zero.
    always_comb begin
        readback = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_sel == IDX_W'(i)) begin
                readback = slot_time[i];
            end
        end
    end

    assign alarm_time_ms_hr  = readback.ms_hr;
    assign alarm_time_ls_hr  = readback.ls_hr;
    assign alarm_time_ms_min = readback.ms_min;
    assign alarm_time_ls_min = readback.ls_min;

endmodule

// File: tb/tb_multi_alarm_engine.sv
// Bench for multi_alarm_engine: directed scenarios plus random traffic, all
// compared cycle by cycle against a minute-of-day reference model.
`timescale 1ns/1ps
module tb_multi_alarm_engine;

    localparam int NA  = 4;
    localparam int SNZ = 5;
    localparam int TO  = 10;
    localparam int W   = 48;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- DUT signals ----------------
    logic       one_minute;
    logic [3:0] cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
    logic       load_new_alarm;
    logic [1:0] alarm_sel;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
    logic       set_enable;
    logic       alarm_enable_val;
    logic       snooze;
    logic       stop;
    logic [3:0] rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min;
    logic [3:0] ringing;
    logic       alarm_sound;
    logic [1:0] active_alarm;

    logic       load5;
    logic [2:0] sel5;
    logic       set_en5;
    logic [3:0] rb5_ms_hr, rb5_ls_hr, rb5_ms_min, rb5_ls_min;
    logic [4:0] ringing5;
    logic       sound5;
    logic [2:0] active5;

    multi_alarm_engine #(.NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(TO)) dut (
        .clock(clock), .reset(reset), .one_minute(one_minute),
        .current_time_ms_hr(cur_ms_hr), .current_time_ls_hr(cur_ls_hr),
        .current_time_ms_min(cur_ms_min), .current_time_ls_min(cur_ls_min),
        .load_new_alarm(load_new_alarm), .alarm_sel(alarm_sel),
        .new_alarm_ms_hr(new_ms_hr), .new_alarm_ls_hr(new_ls_hr),
        .new_alarm_ms_min(new_ms_min), .new_alarm_ls_min(new_ls_min),
        .set_enable(set_enable), .alarm_enable_val(alarm_enable_val),
        .snooze(snooze), .stop(stop),
        .alarm_time_ms_hr(rb_ms_hr), .alarm_time_ls_hr(rb_ls_hr),
        .alarm_time_ms_min(rb_ms_min), .alarm_time_ls_min(rb_ls_min),
        .ringing(ringing), .alarm_sound(alarm_sound), .active_alarm(active_alarm)
    );

    // Five-slot instance so that select value 5 is representable and out of range.
    multi_alarm_engine #(.NUM_ALARMS(5), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(TO)) dut5 (
        .clock(clock), .reset(reset), .one_minute(one_minute),
        .current_time_ms_hr(cur_ms_hr), .current_time_ls_hr(cur_ls_hr),
        .current_time_ms_min(cur_ms_min), .current_time_ls_min(cur_ls_min),
        .load_new_alarm(load5), .alarm_sel(sel5),
        .new_alarm_ms_hr(new_ms_hr), .new_alarm_ls_hr(new_ls_hr),
        .new_alarm_ms_min(new_ms_min), .new_alarm_ls_min(new_ls_min),
        .set_enable(set_en5), .alarm_enable_val(alarm_enable_val),
        .snooze(snooze), .stop(stop),
        .alarm_time_ms_hr(rb5_ms_hr), .alarm_time_ls_hr(rb5_ls_hr),
        .alarm_time_ms_min(rb5_ms_min), .alarm_time_ls_min(rb5_ls_min),
        .ringing(ringing5), .alarm_sound(sound5), .active_alarm(active5)
    );

    // ---------------- reference model (minutes of day) ----------------
    int cur_min;
    int new_min;
    int m_alarm [NA];
    bit m_en    [NA];
    bit m_ring  [NA];
    int m_left  [NA];   // snooze minutes remaining; 0 means not snoozed
    int m_rung  [NA];   // minutes spent ringing since (re)start
    int m5_alarm[5];
    bit m_tick;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [15:0] to_bcd(input int mins);
        int h, m;
        h = mins / 60;
        m = mins % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [W-1:0] expected();
        logic [3:0]  r;
        logic [1:0]  a;
        logic [15:0] rb, rb5;
        r = '0;
        a = '0;
        for (int i = NA - 1; i >= 0; i--) begin
            r[i] = m_ring[i];
            if (m_ring[i]) a = 2'(i);
        end
        rb  = to_bcd(m_alarm[alarm_sel]);
        rb5 = (sel5 < 3'd5) ? to_bcd(m5_alarm[sel5]) : 16'h0;
        return {r, a, |r, rb, 5'b0, 3'b0, 1'b0, rb5};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_alarm[i] = 0; m_en[i] = 0; m_ring[i] = 0; m_left[i] = 0; m_rung[i] = 0;
        end
        for (int i = 0; i < 5; i++) m5_alarm[i] = 0;
        m_tick = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NA; i++) begin
            bit hit, snoozed, idle, hits_now;
            hit      = (int'(alarm_sel) == i);
            snoozed  = (m_left[i] > 0);
            idle     = !m_ring[i] && !snoozed;
            hits_now = m_tick && m_en[i] && (m_alarm[i] == cur_min);
            if (load_new_alarm && hit) m_alarm[i] = new_min;
            if (set_enable && hit) m_en[i] = alarm_enable_val;
            if ((load_new_alarm && hit) || (set_enable && hit && !alarm_enable_val) || stop) begin
                m_ring[i] = 0; m_left[i] = 0; m_rung[i] = 0;
            end else if (m_ring[i] && snooze) begin
                m_ring[i] = 0; m_left[i] = SNZ;
            end else if (m_ring[i] && one_minute) begin
                m_rung[i]++;
                if (m_rung[i] >= TO) m_ring[i] = 0;
            end else if (snoozed && one_minute) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_ring[i] = 1; m_rung[i] = 0;
                end
            end else if (idle && hits_now) begin
                m_ring[i] = 1; m_rung[i] = 0;
            end
        end
        if (load5 && sel5 < 3'd5) m5_alarm[sel5] = new_min;
        m_tick = one_minute;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_time();
        {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = to_bcd(cur_min);
    endtask

    task automatic set_time(input int mins);
        cur_min = mins;
        drive_time();
    endtask

    task automatic set_new(input int mins);
        new_min = mins;
        {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = to_bcd(mins);
    endtask

    // Expectation for the upcoming negedge is the state left by the last edge.
    task automatic step();
        exp_q.push_back(expected());
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic minute();
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        set_time((cur_min + 1) % 1440);
    endtask

    task automatic do_load(input int slot, input int mins);
        alarm_sel = 2'(slot);
        set_new(mins);
        load_new_alarm = 1'b1;
        step();
        load_new_alarm = 1'b0;
    endtask

    task automatic do_enable(input int slot, input bit v);
        alarm_sel = 2'(slot);
        alarm_enable_val = v;
        set_enable = 1'b1;
        step();
        set_enable = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v, act_v;
            exp_v = exp_q.pop_front();
            act_v = {ringing, active_alarm, alarm_sound, rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min,
                     ringing5, active5, sound5, rb5_ms_hr, rb5_ls_hr, rb5_ms_min, rb5_ls_min};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        one_minute = 0; load_new_alarm = 0; alarm_sel = 0; set_enable = 0;
        alarm_enable_val = 0; snooze = 0; stop = 0; load5 = 0; sel5 = 0; set_en5 = 0;
        set_new(0);
        set_time(0);
        model_reset();
        @(posedge clock);
        #1;
        step();
        reset = 1'b1;
        step();
        check("reset_ringing", 32'(ringing), 0);
        check("reset_active", 32'(active_alarm), 0);

        // Slot 2 at 07:30 rings two cycles after the 07:29 -> 07:30 pulse.
        do_load(2, 7 * 60 + 30);
        do_enable(2, 1);
        set_time(7 * 60 + 29);
        step();
        minute();
        check("match_not_yet", 32'(ringing), 0);
        step();
        check("match_ringing", 32'(ringing), 32'b0100);
        check("match_sound", 32'(alarm_sound), 1);
        check("match_active", 32'(active_alarm), 2);

        // Snooze, then ring again after SNZ minutes.
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        check("snooze_silent", 32'(ringing), 0);
        repeat (SNZ - 1) minute();
        check("snooze_still_silent", 32'(ringing), 0);
        minute();
        check("snooze_rering", 32'(ringing), 32'b0100);

        // Unanswered ring auto-stops after TO minutes and stays quiet.
        repeat (TO - 1) minute();
        check("timeout_still_ringing", 32'(ringing), 32'b0100);
        minute();
        check("timeout_idle", 32'(ringing), 0);
        repeat (4) step();
        check("timeout_stays_idle", 32'(ringing), 0);

        // Two slots at 06:00; stop beats snooze in the same cycle.
        do_load(1, 360); do_enable(1, 1);
        do_load(3, 360); do_enable(3, 1);
        set_time(359);
        step();
        minute();
        step();
        check("dual_ringing", 32'(ringing), 32'b1010);
        check("dual_active", 32'(active_alarm), 1);
        snooze = 1'b1; stop = 1'b1;
        step();
        snooze = 1'b0; stop = 1'b0;
        check("stop_over_snooze", 32'(ringing), 0);
        repeat (SNZ + 1) minute();
        check("stop_no_rering", 32'(ringing), 0);

        // Loading the current time does not ring until it recurs.
        set_time(480);
        step();
        do_load(0, 480);
        do_enable(0, 1);
        repeat (3) minute();
        check("load_current_no_ring", 32'(ringing), 0);
        set_time(479);
        minute();
        step();
        check("recur_ring", 32'(ringing), 32'b0001);
        reset = 1'b0;
        step();
        check("midring_reset_sound", 32'(alarm_sound), 0);
        for (int s = 0; s < NA; s++) begin
            alarm_sel = 2'(s);
            #1;
            check("reset_readback", 32'({rb_ms_hr, rb_ls_hr, rb_ms_min, rb_ls_min}), 0);
            step();
        end
        reset = 1'b1;
        step();

        // Disable while ringing; out-of-range select on the five-slot instance.
        do_load(1, 600);
        do_enable(1, 1);
        set_time(599);
        minute();
        step();
        check("disable_pre_ring", 32'(ringing), 32'b0010);
        do_enable(1, 0);
        check("disable_idle", 32'(ringing), 0);
        sel5 = 3'd5; set_new(123); load5 = 1'b1;
        step();
        load5 = 1'b0;
        check("oor_readback", 32'({rb5_ms_hr, rb5_ls_hr, rb5_ms_min, rb5_ls_min}), 0);
        sel5 = 3'd4; set_new(200); load5 = 1'b1;
        step();
        load5 = 1'b0;
        check("slot4_readback", 32'({rb5_ms_hr, rb5_ls_hr, rb5_ms_min, rb5_ls_min}), 32'(to_bcd(200)));
        sel5 = 3'd5;
        step();

        // Random traffic against the model.
        for (int s = 0; s < NA; s++) do_enable(s, 1);
        for (int c = 0; c < 800; c++) begin
            bit tick_now;
            tick_now         = ($urandom_range(0, 99) < 30);
            one_minute       = tick_now;
            alarm_sel        = 2'($urandom_range(0, 3));
            snooze           = ($urandom_range(0, 99) < 5);
            stop             = ($urandom_range(0, 99) < 2);
            load_new_alarm   = ($urandom_range(0, 99) < 6);
            set_enable       = ($urandom_range(0, 99) < 5);
            alarm_enable_val = ($urandom_range(0, 99) < 70);
            load5            = ($urandom_range(0, 99) < 5);
            sel5             = 3'($urandom_range(0, 7));
            set_new((cur_min + int'($urandom_range(0, 4))) % 1440);
            step();
            one_minute = 0; snooze = 0; stop = 0; load_new_alarm = 0; set_enable = 0; load5 = 0;
            if (tick_now) set_time((cur_min + 1) % 1440);
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
